// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement buffer for the Tomasulo core. One entry is allocated
//   per issued instruction. Results are captured from the ALU and load/store
//   CDB ports. The head entry retires in program order as a
//   (reg, tag, value) commit. A retiring mispredicted branch raises a
//   one-cycle flush and empties the buffer.
//
//   Tags are slot index + 1. Tag 0 means "no tag".
//
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     rdy                    global ready; low freezes all state and outputs
//     in_decode_*            allocation request (dest reg, branch flag)
//     out_decode_rob_tag     tag the next allocation receives (tail + 1)
//     out_rob_full           registered count equals ROB_DEPTH
//     in_query_tag1/2        operand tag lookups
//     out_query_ready1/2     queried entry has its result
//     out_query_value1/2     queried entry's value
//     in_alu_*               ALU CDB (value, mispredict, redirect target)
//     in_lsb_*               load/store CDB (value)
//     out_commit_reg/rob/value   registered commit; reg and rob are 0 when idle
//     out_flush, out_flush_pc    registered mispredict redirect pulse
//
//   Build option:
//     ROB_CDB_BYPASS_EN  query ports also see the current-cycle CDB writes

module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_decode_valid,
  input  logic [4:0]       in_decode_dest_reg,
  input  logic             in_decode_is_branch,
  output logic [TAG_W-1:0] out_decode_rob_tag,
  output logic             out_rob_full,
  input  logic [TAG_W-1:0] in_query_tag1,
  input  logic [TAG_W-1:0] in_query_tag2,
  output logic             out_query_ready1,
  output logic             out_query_ready2,
  output logic [31:0]      out_query_value1,
  output logic [31:0]      out_query_value2,
  input  logic             in_alu_valid,
  input  logic [TAG_W-1:0] in_alu_tag,
  input  logic [31:0]      in_alu_value,
  input  logic             in_alu_mispredict,
  input  logic [31:0]      in_alu_target_pc,
  input  logic             in_lsb_valid,
  input  logic [TAG_W-1:0] in_lsb_tag,
  input  logic [31:0]      in_lsb_value,
  output logic [4:0]       out_commit_reg,
  output logic [TAG_W-1:0] out_commit_rob,
  output logic [31:0]      out_commit_value,
  output logic             out_flush,
  output logic [31:0]      out_flush_pc
);

  localparam int ADDR_W = $clog2(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [ROB_DEPTH-1:0] br_q;
  logic [ROB_DEPTH-1:0] misp_q;
  logic [4:0]           dest_q  [ROB_DEPTH];
  logic [31:0]          value_q [ROB_DEPTH];
  logic [31:0]          pc_q    [ROB_DEPTH];

  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [ADDR_W:0]   count_q;

  logic              do_alloc;
  logic              do_commit;
  logic              do_flush;
  logic              alu_wr;
  logic              lsb_wr;
  logic [ADDR_W-1:0] alu_idx;
  logic [ADDR_W-1:0] lsb_idx;

  function automatic logic [ADDR_W-1:0] slot_of(input logic [TAG_W-1:0] tag);
    return ADDR_W'(tag - TAG_W'(1));
  endfunction

  // Returns {ready, value} for a query tag.
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] tag);
    logic [ADDR_W-1:0] idx;
    logic [32:0]       res;
    res = '0;
    idx = slot_of(tag);
    if (tag != '0) begin
      res = {busy_q[idx] && ready_q[idx], value_q[idx]};
`ifdef ROB_CDB_BYPASS_EN
      if (in_lsb_valid && in_lsb_tag == tag) res = {1'b1, in_lsb_value};
      if (in_alu_valid && in_alu_tag == tag) res = {1'b1, in_alu_value};
`endif
    end
    return res;
  endfunction

  assign out_rob_full       = (count_q == (ADDR_W+1)'(ROB_DEPTH));
  assign out_decode_rob_tag = TAG_W'(tail_q) + TAG_W'(1);

  always_comb begin
    {out_query_ready1, out_query_value1} = lookup(in_query_tag1);
    {out_query_ready2, out_query_value2} = lookup(in_query_tag2);
  end

  always_comb begin
    do_commit = busy_q[head_q] && ready_q[head_q];
    // Only branch entries can redirect; a stray mispredict bit on any other
    // entry retires normally.
    do_flush  = do_commit && misp_q[head_q] && br_q[head_q];
    do_alloc  = in_decode_valid && !out_rob_full && !do_flush;
    alu_wr    = in_alu_valid && (in_alu_tag != '0);
    lsb_wr    = in_lsb_valid && (in_lsb_tag != '0);
    alu_idx   = slot_of(in_alu_tag);
    lsb_idx   = slot_of(in_lsb_tag);
  end

  // Later non-blocking writes to the same entry override earlier ones:
  // allocate, then writeback, then commit, then flush clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      busy_q           <= '0;
      ready_q          <= '0;
      br_q             <= '0;
      misp_q           <= '0;
      out_commit_reg   <= '0;
      out_commit_rob   <= '0;
      out_commit_value <= '0;
      out_flush        <= 1'b0;
      out_flush_pc     <= '0;
    end else if (rdy) begin
      out_commit_reg   <= '0;
      out_commit_rob   <= '0;
      out_commit_value <= '0;
      out_flush        <= 1'b0;
      out_flush_pc     <= '0;

      if (do_alloc) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        misp_q[tail_q]  <= 1'b0;
        br_q[tail_q]    <= in_decode_is_branch;
        dest_q[tail_q]  <= in_decode_dest_reg;
        tail_q          <= tail_q + ADDR_W'(1);
      end

      if (alu_wr) begin
        ready_q[alu_idx] <= 1'b1;
        value_q[alu_idx] <= in_alu_value;
        misp_q[alu_idx]  <= in_alu_mispredict;
        pc_q[alu_idx]    <= in_alu_target_pc;
      end

      if (lsb_wr) begin
        ready_q[lsb_idx] <= 1'b1;
        value_q[lsb_idx] <= in_lsb_value;
      end

      if (do_commit) begin
        out_commit_reg   <= dest_q[head_q];
        out_commit_rob   <= TAG_W'(head_q) + TAG_W'(1);
        out_commit_value <= value_q[head_q];
        busy_q[head_q]   <= 1'b0;
        ready_q[head_q]  <= 1'b0;
        head_q           <= head_q + ADDR_W'(1);
      end

      if (do_alloc && !do_commit)      count_q <= count_q + (ADDR_W+1)'(1);
      else if (!do_alloc && do_commit) count_q <= count_q - (ADDR_W+1)'(1);

      if (do_flush) begin
        out_flush    <= 1'b1;
        out_flush_pc <= pc_q[head_q];
        busy_q       <= '0;
        ready_q      <= '0;
        misp_q       <= '0;
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
      end
    end
  end

endmodule
